// File: rtl/uart_tx_scheduler.sv
// Round-robin, message-level arbiter sharing one 8N2 UART transmitter between NUM_REQ byte streams.
// Optional mid-message idle timeout is compiled in with `define UART_TX_TIMEOUT_EN.

module uart_tx_sched_lane (
    input  logic       sel,
    input  logic       accepting,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       last,
    output logic       ready,
    output logic [7:0] dataSel,
    output logic       lastSel
);
    assign ready   = accepting & sel & valid;
    assign dataSel = sel ? data : 8'h00;
    assign lastSel = sel & last;
endmodule

module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 FPGA_CLK1_50,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 TxD_start,
    output logic [7:0]           TxD_data,
    input  logic                 TxD_busy,
    output logic                 timeout
);
    localparam int PW = $clog2(NUM_REQ);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ACCEPT    = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]               state;
    logic [PW-1:0]            rrPtr, gIdx, pickIdx, nextPtr;
    logic                     pickFound, lastFlag, accepting, accepted, selLast, toFire;
    logic [PW:0]              sum;
    logic [7:0]               selData;
    logic [NUM_REQ-1:0][7:0]  laneDataIn, laneDataSel;
    logic [NUM_REQ-1:0]       laneLastSel;

    assign laneDataIn = req_data;
    assign accepting  = (state == ACCEPT);
    assign accepted   = |req_ready;
    assign selLast    = |laneLastSel;
    assign TxD_start  = (state == START);
    assign nextPtr    = (gIdx == PW'(NUM_REQ-1)) ? '0 : gIdx + 1'b1;

    genvar i;
    generate
        for (i = 0; i < NUM_REQ; i++) begin : g_lane
            uart_tx_sched_lane u_lane (
                .sel      (grant[i]),
                .accepting(accepting),
                .valid    (req_valid[i]),
                .data     (laneDataIn[i]),
                .last     (req_last[i]),
                .ready    (req_ready[i]),
                .dataSel  (laneDataSel[i]),
                .lastSel  (laneLastSel[i])
            );
        end
    endgenerate

    always_comb begin
        selData = '0;
        for (int k = 0; k < NUM_REQ; k++) selData |= laneDataSel[k];
    end

    // Scan from the highest offset down so the lowest offset from rrPtr wins.
    always_comb begin
        pickIdx   = '0;
        pickFound = 1'b0;
        sum       = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            sum = {1'b0, rrPtr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
            if (req_valid[sum[PW-1:0]]) begin
                pickIdx   = sum[PW-1:0];
                pickFound = 1'b1;
            end
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            gIdx     <= '0;
            rrPtr    <= '0;
            TxD_data <= 8'h00;
            lastFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!TxD_busy && pickFound) begin
                    grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
                    gIdx  <= pickIdx;
                    state <= ACCEPT;
                end
                ACCEPT: if (toFire) begin
                    grant <= '0;
                    rrPtr <= nextPtr;
                    state <= IDLE;
                end else if (accepted) begin
                    TxD_data <= selData;
                    lastFlag <= selLast;
                    state    <= START;
                end
                START:     state <= WAIT_BUSY;
                WAIT_BUSY: if (TxD_busy) state <= WAIT_DONE;
                WAIT_DONE: if (!TxD_busy) begin
                    if (lastFlag) begin
                        grant <= '0;
                        rrPtr <= nextPtr;
                        state <= IDLE;
                    end else begin
                        state <= ACCEPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES+1);

    logic [CW-1:0] toCnt;
    logic          midMsg;

    // The first byte of a message may wait forever; only later bytes are timed.
    assign toFire = accepting && midMsg && !req_valid[gIdx] && (toCnt == CW'(TIMEOUT_CYCLES-1));

    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            toCnt   <= '0;
            midMsg  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= toFire;
            if (state == IDLE)  midMsg <= 1'b0;
            else if (accepted)  midMsg <= 1'b1;
            if (!accepting || !midMsg || req_valid[gIdx] || toFire) toCnt <= '0;
            else toCnt <= toCnt + 1'b1;
        end
    end
`else
    assign toFire  = 1'b0;
    // Keeps the limit parameter referenced when the timeout is compiled out.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule
